// File: rtl/alu_multdiv.sv
// Iterative signed multiply/divide unit with start-pulse / ready-pulse handshake.
// A start (ctrl_mult or ctrl_div) is accepted in any state and aborts any
// operation in flight. The result appears WIDTH+1 clocks after the start edge,
// with a one-cycle data_resultRDY pulse, and is held until the next start.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   ctrl_mult      1-cycle start pulse, A*B (wins over ctrl_div)
//   ctrl_div       1-cycle start pulse, A/B
//   data_operandA  signed operand A / dividend, sampled on the start edge
//   data_operandB  signed operand B / divisor, sampled on the start edge
//   data_result    signed result, held until the next start
//   data_exception overflow / divide-by-zero flag, held with data_result
//   data_resultRDY 1-cycle pulse marking a new result
//   busy           high while an operation is in flight
module alu_multdiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic [W2-1:0]   acc;      // product accumulator, or {remainder, quotient}
  logic [W2-1:0]   opnd;     // shifting multiplicand, or divisor magnitude
  logic [WIDTH-1:0] mplier;  // multiplier magnitude, consumed LSB first
  logic            neg;      // result sign
  logic            op_div;
  logic            b_zero;
  logic            div_ovf;

  logic            start;
  logic [W2-1:0]   mul_prod;
  logic            mul_ovf;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH:0]  div_diff;

  // Two's complement magnitude; MIN maps to 2^(WIDTH-1) as an unsigned value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign start = ctrl_mult | ctrl_div;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a start in any state restarts, multiply has priority
  always_comb begin
    state_nxt = state;
    if (ctrl_mult) begin
      state_nxt = MULT;
    end else if (ctrl_div) begin
      state_nxt = DIV;
    end else begin
      case (state)
        MULT, DIV: if (count == CW'(WIDTH - 1)) state_nxt = DONE;
        DONE:      state_nxt = IDLE;
        default:   state_nxt = state;
      endcase
    end
  end

  // Final sign fixup, overflow detection and the restoring-divide trial subtract
  always_comb begin
    mul_prod = neg ? -acc : acc;
    mul_ovf  = mul_prod[W2-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}};
    div_quot = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // Partial remainder shifted left by one, minus the divisor
    div_diff = {1'b0, acc[W2-2:WIDTH-1]} - {1'b0, opnd[WIDTH-1:0]};
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      count          <= '0;
      acc            <= '0;
      opnd           <= '0;
      mplier         <= '0;
      neg            <= 1'b0;
      op_div         <= 1'b0;
      b_zero         <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        count   <= '0;
        busy    <= 1'b1;
        neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        op_div  <= ~ctrl_mult;
        b_zero  <= data_operandB == '0;
        div_ovf <= (data_operandA == MIN_VAL) && (data_operandB == '1);
        mplier  <= mag(data_operandB);
        opnd    <= {{WIDTH{1'b0}}, ctrl_mult ? mag(data_operandA) : mag(data_operandB)};
        acc     <= ctrl_mult ? '0 : {{WIDTH{1'b0}}, mag(data_operandA)};
      end else begin
        case (state)
          MULT: begin
            if (mplier[0]) acc <= acc + opnd;
            opnd   <= opnd << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
          end
          DIV: begin
            // Keep the subtraction only when it does not go negative
            if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= acc << 1;
            count <= count + CW'(1);
          end
          DONE: begin
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            if (!op_div) begin
              data_result    <= mul_prod[WIDTH-1:0];
              data_exception <= mul_ovf;
            end else if (b_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else begin
              // MIN / -1 already yields MIN after the sign fixup
              data_result    <= div_quot;
              data_exception <= div_ovf;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
